// File: rtl/aline_acq_ctrl_if.sv
// Write-bus and readout handshake between the A-line acquisition controller
// and the ping-pong sample RAM / reader.
`timescale 1ns/1ps
interface aline_acq_ctrl_if;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [13:0] wr_data;
  logic        aline_ready;
  logic        rd_bank;
  logic        aline_ack;

  modport master (
    output wr_en, wr_addr, wr_data, aline_ready, rd_bank,
    input  aline_ack
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, aline_ready, rd_bank,
    output aline_ack
  );
endinterface

// File: rtl/aline_acq_ctrl.sv
// Swept-source OCT A-line capture: syncs the laser sweep trigger, streams
// NSAMPLES ADC words into one of two RAM banks and tracks which bank is full.
`timescale 1ns/1ps
module aline_acq_ctrl #(
  parameter int NSAMPLES   = 1170,
  parameter int TRIG_DELAY = 0
) (
  input  logic             ADC_data_out_clk,
  input  logic             global_reset_n,
  input  logic             arm,
  input  logic             sweep_trig,
  input  logic [13:0]      ADC_chanA,
  aline_acq_ctrl_if.master bus,
  output logic             acq_busy,
  output logic [15:0]      aline_cnt,
  output logic [15:0]      overrun_cnt
);
  typedef enum logic [1:0] {IDLE, DELAY, ACQ, DONE} state_t;

  localparam logic [10:0] IDX_LAST = 11'(NSAMPLES - 1);
  localparam logic [7:0]  DLY_LAST = 8'((TRIG_DELAY > 0) ? TRIG_DELAY - 1 : 0);

  state_t      state_reg;
  logic        trig_sync1_reg, trig_sync2_reg, trig_sync3_reg;
  logic [1:0]  prime_reg;
  logic        trig_low_seen_reg;
  logic        trig_event;
  logic [7:0]  dly_cnt_reg;
  logic [10:0] idx_reg;
  logic        wr_bank_reg;
  logic        rd_bank_reg;
  logic        bank_full_reg [2];
  logic        ack_accept;
  logic        wr_en_reg;
  logic [11:0] wr_addr_reg;
  logic [13:0] wr_data_reg;
  logic        acq_busy_reg;
  logic [15:0] aline_cnt_reg;
  logic [15:0] overrun_cnt_reg;

  // An edge only counts once the chain has shown the trigger low after reset,
  // so a trigger held high through reset release cannot start an A-line.
  always_ff @(posedge ADC_data_out_clk or negedge global_reset_n) begin
    if (!global_reset_n) begin
      trig_sync1_reg    <= 1'b0;
      trig_sync2_reg    <= 1'b0;
      trig_sync3_reg    <= 1'b0;
      prime_reg         <= 2'b00;
      trig_low_seen_reg <= 1'b0;
    end else begin
      trig_sync1_reg <= sweep_trig;
      trig_sync2_reg <= trig_sync1_reg;
      trig_sync3_reg <= trig_sync2_reg;
      prime_reg      <= {prime_reg[0], 1'b1};
      if (prime_reg[1] && !trig_sync2_reg)
        trig_low_seen_reg <= 1'b1;
    end
  end

  assign trig_event = trig_sync2_reg & ~trig_sync3_reg & trig_low_seen_reg;

  always_ff @(posedge ADC_data_out_clk or negedge global_reset_n) begin
    if (!global_reset_n) begin
      state_reg       <= IDLE;
      dly_cnt_reg     <= '0;
      idx_reg         <= '0;
      wr_bank_reg     <= 1'b0;
      wr_en_reg       <= 1'b0;
      wr_addr_reg     <= '0;
      wr_data_reg     <= '0;
      acq_busy_reg    <= 1'b0;
      aline_cnt_reg   <= '0;
      overrun_cnt_reg <= '0;
    end else begin
      wr_en_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (trig_event && arm) begin
            if (bank_full_reg[wr_bank_reg]) begin
              if (overrun_cnt_reg != 16'hFFFF)
                overrun_cnt_reg <= overrun_cnt_reg + 16'd1;
            end else begin
              dly_cnt_reg  <= '0;
              idx_reg      <= '0;
              acq_busy_reg <= 1'b1;
              state_reg    <= (TRIG_DELAY > 0) ? DELAY : ACQ;
            end
          end
        end
        DELAY: begin
          if (dly_cnt_reg == DLY_LAST)
            state_reg <= ACQ;
          else
            dly_cnt_reg <= dly_cnt_reg + 8'd1;
        end
        ACQ: begin
          wr_en_reg   <= 1'b1;
          wr_addr_reg <= {wr_bank_reg, idx_reg};
          wr_data_reg <= ADC_chanA;
          idx_reg     <= idx_reg + 11'd1;
          if (idx_reg == IDX_LAST) begin
            acq_busy_reg <= 1'b0;
            state_reg    <= DONE;
          end
        end
        DONE: begin
          wr_bank_reg   <= ~wr_bank_reg;
          aline_cnt_reg <= aline_cnt_reg + 16'd1;
          state_reg     <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign ack_accept = bus.aline_ack & bank_full_reg[rd_bank_reg];

  // DONE and an accepted ack always address different banks, so each bank
  // flag sees at most one of the two events in any clock.
  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    always_ff @(posedge ADC_data_out_clk or negedge global_reset_n) begin
      if (!global_reset_n)
        bank_full_reg[gi] <= 1'b0;
      else if (state_reg == DONE && wr_bank_reg == 1'(gi))
        bank_full_reg[gi] <= 1'b1;
      else if (ack_accept && rd_bank_reg == 1'(gi))
        bank_full_reg[gi] <= 1'b0;
    end
  end

  always_ff @(posedge ADC_data_out_clk or negedge global_reset_n) begin
    if (!global_reset_n)
      rd_bank_reg <= 1'b0;
    else if (ack_accept)
      rd_bank_reg <= ~rd_bank_reg;
  end

  assign bus.wr_en       = wr_en_reg;
  assign bus.wr_addr     = wr_addr_reg;
  assign bus.wr_data     = wr_data_reg;
  assign bus.aline_ready = bank_full_reg[rd_bank_reg];
  assign bus.rd_bank     = rd_bank_reg;
  assign acq_busy        = acq_busy_reg;
  assign aline_cnt       = aline_cnt_reg;
  assign overrun_cnt     = overrun_cnt_reg;
endmodule

// File: doc/aline_acq_ctrl.md
ALINE_ACQ_CTRL -- requirements
Module: aline_acq_ctrl

Interface
REQ-001 SHALL have parameter NSAMPLES, default 1170, samples written per A-line (range 2..2047).
REQ-002 SHALL have parameter TRIG_DELAY, default 0, clocks between detected trigger and first sample write (0..255).
REQ-003 SHALL have port ADC_data_out_clk  in  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port global_reset_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port arm  in  1  level; 1 = triggers accepted.
REQ-006 SHALL have port sweep_trig  in  1  asynchronous laser sweep trigger, rising edge starts an A-line.
REQ-007 SHALL have port ADC_chanA  in  14  ADC sample, valid every clock.
REQ-008 SHALL have port aline_ack  in  1  single-cycle pulse from reader, frees oldest full bank.
REQ-009 SHALL have port wr_en  out  1  RAM write strobe.
REQ-010 SHALL have port wr_addr  out  12  RAM write address {bank, sample index[10:0]}.
REQ-011 SHALL have port wr_data  out  14  RAM write data.
REQ-012 SHALL have port acq_busy  out  1  high in DELAY or ACQ.
REQ-013 SHALL have port aline_ready  out  1  at least one full bank awaiting readout.
REQ-014 SHALL have port rd_bank  out  1  bank the reader shall read next.
REQ-015 SHALL have port aline_cnt  out  16  completed A-lines, wraps modulo 2^16.
REQ-016 SHALL have port overrun_cnt  out  16  triggers dropped for lack of a free bank, saturates at 0xFFFF.

Function
REQ-017 sweep_trig SHALL pass a 2-flop synchronizer plus one edge-detect flop; trigger event = sync2 & ~sync3.
REQ-018 FSM states SHALL be IDLE, DELAY, ACQ, DONE; all registered.
REQ-019 IDLE: trigger event with arm=1 and bank_full[wr_bank]=0 -> DELAY (TRIG_DELAY>0) or ACQ (TRIG_DELAY=0); delay counter and sample index cleared.
REQ-020 IDLE: trigger event with arm=1 and bank_full[wr_bank]=1 -> stay IDLE, overrun_cnt +1 (saturating).
REQ-021 IDLE: trigger event with arm=0 SHALL be ignored and not counted.
REQ-022 DELAY: count TRIG_DELAY clocks, then -> ACQ.
REQ-023 ACQ: each clock wr_en=1, wr_addr={wr_bank, index}, index +1; after index NSAMPLES-1 written -> DONE.
REQ-024 wr_en, wr_addr, wr_data SHALL be registered together; wr_data = ADC_chanA sampled at the same edge that asserts the matching wr_en.
REQ-025 Exactly NSAMPLES writes per A-line, addresses 0..NSAMPLES-1 contiguous, no gaps.
REQ-026 DONE (one clock): bank_full[wr_bank] set, wr_bank toggles, aline_cnt +1, -> IDLE.
REQ-027 Trigger events in DELAY, ACQ or DONE SHALL be ignored and not counted.
REQ-028 arm falling during DELAY/ACQ SHALL NOT abort; current A-line completes.
REQ-029 aline_ready = bank_full[rd_bank]; aline_ack while aline_ready=1 clears bank_full[rd_bank] and toggles rd_bank next edge.
REQ-030 aline_ack while aline_ready=0 SHALL be ignored.
REQ-031 DONE set and aline_ack clear in the same clock SHALL both take effect (always different banks).
REQ-032 Minimum trigger-to-first-write latency (TRIG_DELAY=0): wr_en high after 4th rising edge counting the first edge sampling sweep_trig=1.

Reset
REQ-033 Asserted reset SHALL force: state IDLE, wr_en=0, wr_addr=0, wr_data=0, acq_busy=0, aline_ready=0, rd_bank=0, wr_bank=0, bank_full=2'b00, aline_cnt=0, overrun_cnt=0, synchronizer flops 0.
REQ-034 Reset mid-ACQ SHALL discard the partial A-line; no bank marked full; no write after reset assertion.
REQ-035 A trigger held high across reset release SHALL NOT start an A-line (no edge after sync flops clear... first edge requires sweep_trig low then high).

Verification
REQ-036 NSAMPLES=1170, arm=1, ramp ADC data, one trigger -> 1170 writes addr 0x000..0x491, data = ramp delayed 1 clock, aline_ready=1, rd_bank=0, aline_cnt=1.
REQ-037 Three triggers, no ack -> banks 0 and 1 filled (addr bit11 = 0 then 1), third trigger dropped, overrun_cnt=1, aline_cnt=2.
REQ-038 Ack after each A-line over 10 triggers -> rd_bank alternates 0,1,0..., overrun_cnt=0, aline_cnt=10.
REQ-039 TRIG_DELAY=5, trigger -> first wr_en exactly 5 clocks later than TRIG_DELAY=0 case; retrigger mid-ACQ -> no effect, no count.
REQ-040 Reset asserted at sample 500 -> all outputs at REQ-033 values immediately; next trigger writes bank 0 from address 0.
REQ-041 DONE and aline_ack in same clock -> bank_full shows new bank set and old bank cleared; aline_ready stays 1.
